// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a CPU port and a loader port onto one shared
// memory with a fixed read latency of MEM_LAT cycles (legal range 1..4).
// A transaction runs from the grant cycle in IDLE, through MEM_LAT BUSY
// cycles, to a single DONE cycle that pulses the winner's ack.
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_ack,
  output logic [31:0] cpu_rd,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_adr,
  input  logic [31:0] ldr_wd,
  output logic        ldr_ack,
  output logic [31:0] ldr_rd,
  input  logic        ldr_prio,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // The BUSY counter is loaded with MEM_LAT-1 and the last BUSY cycle is
  // the one where it reads zero.
  localparam logic [1:0] LAT_INIT  = 2'(MEM_LAT - 1);
  localparam logic       GRANT_CPU = 1'b0;
  localparam logic       GRANT_LDR = 1'b1;

  state_t      state;
  state_t      state_next;
  logic [1:0]  cnt;
  logic        last_grant;
  logic        owner;
  logic [31:0] lat_adr;
  logic [31:0] lat_wd;
  logic        lat_we;
  logic        any_req;
  logic        pick_ldr;
  logic        last_cycle;

  // Arbitration: a lone requester wins; on a tie the loader wins if it has
  // priority, otherwise whoever was not granted last wins.
  always_comb begin
    any_req    = cpu_req | ldr_req;
    pick_ldr   = ldr_req & (~cpu_req | ldr_prio | (last_grant == GRANT_CPU));
    last_cycle = (cnt == 2'd0);
  end

  // State register; reset returns to IDLE from anywhere, aborting any
  // transaction in flight without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and all state-decoded outputs; the memory bus is
  // quiet outside BUSY and the write strobe fires only in the first BUSY cycle.
  always_comb begin
    state_next = IDLE;
    busy       = 1'b1;
    cpu_ack    = 1'b0;
    ldr_ack    = 1'b0;
    mem_adr    = 32'h0;
    mem_wd     = 32'h0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        state_next = any_req ? BUSY : IDLE;
      end
      BUSY: begin
        mem_adr    = lat_adr;
        mem_wd     = lat_wd;
        mem_we     = lat_we & (cnt == LAT_INIT);
        state_next = last_cycle ? DONE : BUSY;
      end
      DONE: begin
        cpu_ack    = (owner == GRANT_CPU);
        ldr_ack    = (owner == GRANT_LDR);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the winner's request at grant, count down the BUSY
  // cycles, and capture read data (or zero for writes) into the winner's
  // rd register on the last BUSY cycle. rd registers hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 2'd0;
      last_grant <= GRANT_LDR;
      owner      <= GRANT_CPU;
      lat_adr    <= 32'h0;
      lat_wd     <= 32'h0;
      lat_we     <= 1'b0;
      cpu_rd     <= 32'h0;
      ldr_rd     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= pick_ldr;
            last_grant <= pick_ldr;
            lat_adr    <= pick_ldr ? ldr_adr : cpu_adr;
            lat_wd     <= pick_ldr ? ldr_wd  : cpu_wd;
            lat_we     <= pick_ldr ? ldr_we  : cpu_we;
            cnt        <= LAT_INIT;
          end
        end
        BUSY: begin
          if (!last_cycle) begin
            cnt <= cnt - 2'd1;
          end else if (owner == GRANT_LDR) begin
            ldr_rd <= lat_we ? 32'h0 : mem_rd;
          end else begin
            cpu_rd <= lat_we ? 32'h0 : mem_rd;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
